alu_seq_unit: RTL and testbench

- Parametrised ALU execution unit. Decodes {alu_op_i, alu_function_i}, executes single-cycle ops into a registered result, and runs multi-cycle unsigned multiply into HI/LO.
- Start/ready handshake: the pipeline stalls on ready_o.
- Sits in EX stage; replaces separate ALU-control decode + combinational ALU.

---
 rtl/alu_seq_unit.sv | 204 ++++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: EX-stage ALU with registered single-cycle ops and a shift-add MULTU into HI/LO.
// Define ALU_SEQ_DIVU_EN to add a restoring DIVU sharing the same handshake and latency.
module alu_seq_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic [2:0]             alu_op_i,
    input  logic [5:0]             alu_function_i,
    input  logic [SHAMT_WIDTH-1:0] shamt_i,
    input  logic [DATA_WIDTH-1:0]  a_i,
    input  logic [DATA_WIDTH-1:0]  b_i,
    output logic                   ready_o,
    output logic                   result_valid_o,
    output logic [DATA_WIDTH-1:0]  result_o,
    output logic                   zero_o,
    output logic                   illegal_o,
    output logic [DATA_WIDTH-1:0]  hi_o,
    output logic [DATA_WIDTH-1:0]  lo_o
);
    localparam int W = DATA_WIDTH;
`ifdef ALU_SEQ_DIVU_EN
    typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;
`else
    typedef enum logic {IDLE, MULT} state_t;
`endif
    state_t               state_q, state_d;
    logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]       acc_q, acc_d, mcand_q, mcand_d, acc_next;
    logic [W-1:0]         mplier_q, mplier_d;
    logic [W-1:0]         hi_q, hi_d, lo_q, lo_d, result_q, result_d;
    logic                 valid_q, valid_d, zero_q, zero_d, illegal_q, illegal_d;
    logic [W-1:0]         op_res;
    logic                 op_mul, op_div, op_ill;
`ifdef ALU_SEQ_DIVU_EN
    logic [W-1:0]         rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
    logic [W:0]           rem_shift, diff;
    logic                 ge;
`endif

    always_comb begin
        op_res = '0;
        op_mul = 1'b0;
        op_div = 1'b0;
        op_ill = 1'b0;
        case (alu_op_i)
            3'b111: case (alu_function_i)
                6'b100000: op_res = a_i + b_i;
                6'b100010: op_res = a_i - b_i;
                6'b100100: op_res = a_i & b_i;
                6'b100101: op_res = a_i | b_i;
                6'b000000: op_res = b_i << shamt_i;
                6'b000010: op_res = b_i >> shamt_i;
                6'b010000: op_res = hi_q;
                6'b010010: op_res = lo_q;
                6'b011001: op_mul = 1'b1;
`ifdef ALU_SEQ_DIVU_EN
                6'b011011: op_div = 1'b1;
`endif
                default:   op_ill = 1'b1;
            endcase
            3'b100:  op_res = a_i + b_i;
            3'b010:  op_res = a_i & b_i;
            3'b001:  op_res = a_i | b_i;
            3'b000:  op_res = {b_i[W/2-1:0], {(W/2){1'b0}}};
            default: op_ill = 1'b1;
        endcase
    end

    assign acc_next = mplier_q[0] ? acc_q + mcand_q : acc_q;
`ifdef ALU_SEQ_DIVU_EN
    // b = 0 naturally yields an all-ones quotient and remainder = a
    assign rem_shift = {rem_q, quo_q[W-1]};
    assign diff      = rem_shift - {1'b0, dvsr_q};
    assign ge        = ~diff[W];
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        valid_d   = 1'b0;
`ifdef ALU_SEQ_DIVU_EN
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
`endif
        case (state_q)
            IDLE: if (start_i) begin
                if (op_mul) begin
                    state_d  = MULT;
                    cnt_d    = SHAMT_WIDTH'(W - 1);
                    acc_d    = '0;
                    mcand_d  = {{W{1'b0}}, a_i};
                    mplier_d = b_i;
                end else if (op_div) begin
`ifdef ALU_SEQ_DIVU_EN
                    state_d = DIV;
                    cnt_d   = SHAMT_WIDTH'(W - 1);
                    rem_d   = '0;
                    quo_d   = a_i;
                    dvsr_d  = b_i;
`endif
                end else begin
                    result_d  = op_res;
                    zero_d    = (op_res == '0);
                    illegal_d = op_ill;
                    valid_d   = 1'b1;
                end
            end
            MULT: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d   = IDLE;
                    hi_d      = acc_next[2*W-1:W];
                    lo_d      = acc_next[W-1:0];
                    result_d  = acc_next[W-1:0];
                    zero_d    = (acc_next[W-1:0] == '0);
                    illegal_d = 1'b0;
                    valid_d   = 1'b1;
                end
            end
`ifdef ALU_SEQ_DIVU_EN
            DIV: begin
                rem_d = ge ? diff[W-1:0] : rem_shift[W-1:0];
                quo_d = {quo_q[W-2:0], ge};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d   = IDLE;
                    hi_d      = rem_d;
                    lo_d      = quo_d;
                    result_d  = quo_d;
                    zero_d    = (quo_d == '0);
                    illegal_d = 1'b0;
                    valid_d   = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            valid_q   <= valid_d;
        end
    end

`ifdef ALU_SEQ_DIVU_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvsr_q <= dvsr_d;
        end
    end
`endif

    assign ready_o        = (state_q == IDLE);
    assign result_valid_o = valid_q;
    assign result_o       = result_q;
    assign zero_o         = zero_q;
    assign illegal_o      = illegal_q;
    assign hi_o           = hi_q;
    assign lo_o           = lo_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed checks of alu_seq_unit with hand-computed expectations.
module tb_alu_seq_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [2:0]  alu_op_i = '0;
    logic [5:0]  alu_function_i = '0;
    logic [4:0]  shamt_i = '0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        ready_o, result_valid_o, zero_o, illegal_o;
    logic [31:0] result_o, hi_o, lo_o;
    int          passed = 0;
    int          total = 0;
    int          n;
    logic        seen;

    alu_seq_unit #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .alu_op_i(alu_op_i),
        .alu_function_i(alu_function_i), .shamt_i(shamt_i), .a_i(a_i), .b_i(b_i),
        .ready_o(ready_o), .result_valid_o(result_valid_o), .result_o(result_o),
        .zero_o(zero_o), .illegal_o(illegal_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called at a negedge; the request is accepted on the following posedge.
    task automatic issue(input logic [2:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b);
        alu_op_i = op; alu_function_i = fn; shamt_i = sh; a_i = a; b_i = b; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; a_i = 32'h5A5A_5A5A; b_i = 32'hA5A5_A5A5;
    endtask

    // Counts busy cycles; optionally pulses an ADD request mid-operation.
    task automatic wait_busy(input bit pulse, output int cnt);
        cnt = 0;
        while (!ready_o && cnt < 100) begin
            cnt++;
            if (pulse && cnt == 10) begin
                alu_op_i = 3'b111; alu_function_i = 6'b100000; a_i = 32'd1; b_i = 32'd1; start_i = 1'b1;
            end else start_i = 1'b0;
            @(negedge clk);
        end
        start_i = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("reset_ready", 64'(ready_o), 64'd1);
        chk("reset_outs", {result_valid_o, zero_o, illegal_o, result_o}, 64'd0);
        chk("reset_hilo", {hi_o, lo_o}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        issue(3'b111, 6'b100000, 5'd0, 32'hFFFF_FFFF, 32'd1);
        chk("add_wrap", {result_valid_o, zero_o, illegal_o, result_o}, {32'd0, 3'b110, 32'd0});
        @(negedge clk);
        chk("valid_pulse", {result_valid_o, result_o}, {31'd0, 1'b0, 32'd0});
        issue(3'b111, 6'b000000, 5'd31, 32'd0, 32'h0000_0001);
        chk("sll", {result_valid_o, result_o}, {31'd0, 1'b1, 32'h8000_0000});
        issue(3'b111, 6'b000010, 5'd31, 32'd0, 32'h8000_0000);
        chk("srl", 64'(result_o), 64'h0000_0001);
        issue(3'b000, 6'b111111, 5'd0, 32'd0, 32'h0000_1234);
        chk("lui", 64'(result_o), 64'h1234_0000);
        issue(3'b111, 6'b100010, 5'd0, 32'd5, 32'd7);
        chk("sub", 64'(result_o), 64'hFFFF_FFFE);
        issue(3'b111, 6'b100100, 5'd0, 32'hF0F0_1234, 32'h0FF0_FF00);
        chk("and", 64'(result_o), 64'h00F0_1200);
        issue(3'b111, 6'b100101, 5'd0, 32'hF000_0001, 32'h0000_0F00);
        chk("or", 64'(result_o), 64'hF000_0F01);
        issue(3'b100, 6'b000000, 5'd0, 32'd100, 32'hFFFF_FFFF);
        chk("addi", 64'(result_o), 64'd99);
        issue(3'b010, 6'b000000, 5'd0, 32'hABCD_EF01, 32'h0000_FFFF);
        chk("andi", 64'(result_o), 64'h0000_EF01);
        issue(3'b001, 6'b000000, 5'd0, 32'hABCD_0000, 32'h0000_1234);
        chk("ori", 64'(result_o), 64'hABCD_1234);
        issue(3'b111, 6'b011001, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_busy(1'b1, n);
        chk("mult_busy_cycles", 64'(n), 64'd32);
        chk("mult_valid_ready", {62'd0, result_valid_o, ready_o}, 64'd3);
        chk("mult_hilo", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);
        chk("mult_result", {illegal_o, result_o}, 64'h0000_0001);
        @(negedge clk);
        chk("mid_start_ignored", {62'd0, result_valid_o, ready_o}, 64'd1);
        issue(3'b111, 6'b010000, 5'd0, 32'd0, 32'd0);
        chk("mfhi", 64'(result_o), 64'hFFFF_FFFE);
        issue(3'b111, 6'b011001, 5'd0, 32'd7, 32'd6);
        wait_busy(1'b0, n);
        chk("mult7x6_valid", 64'(result_valid_o), 64'd1);
        issue(3'b111, 6'b010010, 5'd0, 32'd0, 32'd0);
        chk("b2b_mflo", {result_valid_o, result_o}, {31'd0, 1'b1, 32'd42});
        chk("mult7x6_hi", 64'(hi_o), 64'd0);
        issue(3'b111, 6'b101010, 5'd0, 32'd3, 32'd4);
        chk("illegal_funct", {result_valid_o, zero_o, illegal_o, result_o}, {32'd0, 3'b111, 32'd0});
        chk("illegal_hilo", {hi_o, lo_o}, 64'd42);
        issue(3'b011, 6'b100000, 5'd0, 32'd3, 32'd4);
        chk("illegal_opclass", {illegal_o, result_o}, {31'd0, 1'b1, 32'd0});
`ifdef ALU_SEQ_DIVU_EN
        issue(3'b111, 6'b011011, 5'd0, 32'd100, 32'd7);
        wait_busy(1'b0, n);
        chk("divu_cycles", 64'(n), 64'd32);
        chk("divu_100_7", {hi_o, lo_o}, {32'd2, 32'd14});
        chk("divu_res", {result_valid_o, illegal_o, result_o}, {30'd0, 2'b10, 32'd14});
        @(negedge clk);
        issue(3'b111, 6'b011011, 5'd0, 32'd5, 32'd0);
        wait_busy(1'b0, n);
        chk("divu_by0", {hi_o, lo_o}, {32'd5, 32'hFFFF_FFFF});
        chk("divu_by0_legal", {result_valid_o, illegal_o}, 64'd2);
        @(negedge clk);
`else
        issue(3'b111, 6'b011011, 5'd0, 32'd100, 32'd7);
        chk("divu_illegal", {ready_o, result_valid_o, illegal_o, result_o}, {29'd0, 3'b111, 32'd0});
`endif
        issue(3'b111, 6'b100000, 5'd0, 32'd1, 32'd2);
        chk("illegal_cleared", {illegal_o, result_o}, 64'd3);
        issue(3'b111, 6'b011001, 5'd0, 32'd9, 32'd9);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_ready", 64'(ready_o), 64'd1);
        chk("rst_mid_hilo", {hi_o, lo_o}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= result_valid_o;
        end
        chk("rst_no_valid", 64'(seen), 64'd0);
        issue(3'b111, 6'b100000, 5'd0, 32'd2, 32'd3);
        chk("add_after_rst", {result_valid_o, result_o}, {31'd0, 1'b1, 32'd5});
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
